// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and variable-latency load
// results onto one register-file write port, buffering loads in a small FIFO.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        alu_valid_in,
  output logic        alu_ready_out,
  input  logic [4:0]  alu_rd_in,
  input  logic [31:0] alu_data_in,
  input  logic        ld_valid_in,
  output logic        ld_ready_out,
  input  logic [4:0]  ld_rd_in,
  input  logic [31:0] ld_data_in,
  input  logic [2:0]  ld_funct3_in,
  input  logic [1:0]  ld_addr_lo_in,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] rd_data_out,
  output logic        wr_en_out,
  output logic        misalign_err_out,
  output logic        ld_pending_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [4:0]    ent_rd_q   [DEPTH];
  logic [31:0]   ent_data_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en_q, mis_q;
  logic [4:0]    rd_addr_q;
  logic [31:0]   rd_data_q;

  logic          ready, ld_fire, misalign, ld_ok;
  logic          push, pop, sel;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_fmt;

  // Readiness depends only on registered occupancy, never on this cycle's valids.
  assign ready          = (count_q != CW'(DEPTH));
  assign alu_ready_out  = ready;
  assign ld_ready_out   = ready;
  assign ld_pending_out = (count_q != '0);
  assign ld_fire        = ld_valid_in && ready;

  always_comb begin
    ld_byte  = ld_data_in[{ld_addr_lo_in, 3'b000} +: 8];
    ld_half  = ld_addr_lo_in[1] ? ld_data_in[31:16] : ld_data_in[15:0];
    ld_fmt   = ld_data_in;
    misalign = 1'b0;
    unique case (ld_funct3_in)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b001: begin
        ld_fmt   = {{16{ld_half[15]}}, ld_half};
        misalign = ld_addr_lo_in[0];
      end
      3'b101: begin
        ld_fmt   = {16'd0, ld_half};
        misalign = ld_addr_lo_in[0];
      end
      // lw and the undefined encodings all behave as a full word
      default: misalign = (ld_addr_lo_in != 2'b00);
    endcase
  end

  assign ld_ok = ld_fire && !misalign;

  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    sel      = 1'b0;
    sel_rd   = alu_rd_in;
    sel_data = alu_data_in;
    if (!ready) begin
      pop = 1'b1;
    end else if (alu_valid_in) begin
      sel  = 1'b1;
      push = ld_ok;
    end else if (count_q != '0) begin
      pop  = 1'b1;
      push = ld_ok;
    end else if (ld_ok) begin
      sel      = 1'b1;
      sel_rd   = ld_rd_in;
      sel_data = ld_fmt;
    end
    if (pop) begin
      sel      = 1'b1;
      sel_rd   = ent_rd_q[rd_ptr_q];
      sel_data = ent_data_q[rd_ptr_q];
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      wr_en_q   <= 1'b0;
      mis_q     <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      mis_q   <= ld_fire && misalign;
      // rd = 0 items are still consumed, they just never assert the write
      wr_en_q <= sel && (sel_rd != 5'd0);
      if (sel) begin
        rd_addr_q <= sel_rd;
        rd_data_q <= sel_data;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push) begin
        ent_rd_q[wr_ptr_q]   <= ld_rd_in;
        ent_data_q[wr_ptr_q] <= ld_fmt;
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
    end
  end

  assign wr_en_out        = wr_en_q;
  assign rd_addr_out      = rd_addr_q;
  assign rd_data_out      = rd_data_q;
  assign misalign_err_out = mis_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts every
// register-file write and misalignment pulse; a negedge monitor checks them.
module tb_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        alu_valid_in = 1'b0, ld_valid_in = 1'b0;
  logic        alu_ready_out, ld_ready_out;
  logic [4:0]  alu_rd_in = '0, ld_rd_in = '0;
  logic [31:0] alu_data_in = '0, ld_data_in = '0;
  logic [2:0]  ld_funct3_in = '0;
  logic [1:0]  ld_addr_lo_in = '0;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_data_out;
  logic        wr_en_out, misalign_err_out, ld_pending_out;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .alu_valid_in(alu_valid_in), .alu_ready_out(alu_ready_out),
    .alu_rd_in(alu_rd_in), .alu_data_in(alu_data_in),
    .ld_valid_in(ld_valid_in), .ld_ready_out(ld_ready_out),
    .ld_rd_in(ld_rd_in), .ld_data_in(ld_data_in),
    .ld_funct3_in(ld_funct3_in), .ld_addr_lo_in(ld_addr_lo_in),
    .rd_addr_out(rd_addr_out), .rd_data_out(rd_data_out),
    .wr_en_out(wr_en_out), .misalign_err_out(misalign_err_out),
    .ld_pending_out(ld_pending_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  typedef struct { int due; logic [4:0] rd; logic [31:0] data; } exp_t;

  ent_t mq[$];      // reference load FIFO
  exp_t eq[$];      // expected writes, tagged with the cycle they appear
  int   mis_q[$];   // cycles where a misalignment pulse is expected
  int   cyc = 0;
  int   checks = 0, errors = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lo);
    int unsigned v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * lo)) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * (lo / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic [1:0] lo);
    int size;
    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    return (int'(lo) % size) != 0;
  endfunction

  // One clock of stimulus: check handshake outputs, drive inputs, advance the model.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                      input logic [2:0] f3, input logic [1:0] lo);
    int   n;
    bit   rdy, lacc, mis, lok, have_w;
    ent_t w;
    @(negedge clk_in);
    n = mq.size();
    rdy = (n < DEPTH);
    chk("alu_ready", {31'd0, alu_ready_out}, {31'd0, rdy});
    chk("ld_ready", {31'd0, ld_ready_out}, {31'd0, rdy});
    chk("ld_pending", {31'd0, ld_pending_out}, {31'd0, n != 0});
    rst_in = 1'b0;
    alu_valid_in = av; alu_rd_in = ard; alu_data_in = ad;
    ld_valid_in = lv; ld_rd_in = lrd; ld_data_in = ldd;
    ld_funct3_in = f3; ld_addr_lo_in = lo;
    lacc = lv && rdy;
    mis = is_mis(f3, lo);
    lok = lacc && !mis;
    have_w = 1'b0;
    w = '{rd: 5'd0, data: 32'd0};
    if (!rdy) begin
      w = mq.pop_front(); have_w = 1'b1;
    end else if (av) begin
      w = '{rd: ard, data: ad}; have_w = 1'b1;
      if (lok) mq.push_back('{rd: lrd, data: fmt_load(ldd, f3, lo)});
    end else if (n > 0) begin
      w = mq.pop_front(); have_w = 1'b1;
      if (lok) mq.push_back('{rd: lrd, data: fmt_load(ldd, f3, lo)});
    end else if (lok) begin
      w = '{rd: lrd, data: fmt_load(ldd, f3, lo)}; have_w = 1'b1;
    end
    if (have_w && w.rd != 5'd0) eq.push_back('{due: cyc + 1, rd: w.rd, data: w.data});
    if (lacc && mis) mis_q.push_back(cyc + 1);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    alu_valid_in = 1'b0;
    ld_valid_in = 1'b0;
    @(posedge clk_in);
    #1;
    mq.delete();
  endtask

  // Monitor: every write must match the scoreboard head due this cycle.
  always @(negedge clk_in) begin
    if (mon_en) begin
      bit exp_now, mis_now;
      exp_t e;
      exp_now = (eq.size() > 0) && (eq[0].due == cyc);
      if (wr_en_out !== 1'b0) begin
        checks++;
        if (!exp_now) begin
          errors++;
          $display("FAIL spurious_write: got rd=%0d data=%h expected no write (cycle %0d)",
                   rd_addr_out, rd_data_out, cyc);
        end else begin
          e = eq.pop_front();
          if (rd_addr_out !== e.rd || rd_data_out !== e.data) begin
            errors++;
            $display("FAIL write: got rd=%0d data=%h expected rd=%0d data=%h (cycle %0d)",
                     rd_addr_out, rd_data_out, e.rd, e.data, cyc);
          end else
            $display("write rd=%0d data=%h cycle %0d", rd_addr_out, rd_data_out, cyc);
        end
      end else if (exp_now) begin
        checks++; errors++;
        e = eq.pop_front();
        $display("FAIL missing_write: got wr_en=0 expected rd=%0d data=%h (cycle %0d)",
                 e.rd, e.data, cyc);
      end
      mis_now = (mis_q.size() > 0) && (mis_q[0] == cyc);
      if (mis_now || misalign_err_out !== 1'b0) begin
        chk("misalign_err", {31'd0, misalign_err_out}, {31'd0, mis_now});
        if (mis_now) void'(mis_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [2:0] f3s [8];
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_wr_en", {31'd0, wr_en_out}, 32'd0);
    chk("reset_rd_addr", {27'd0, rd_addr_out}, 32'd0);
    chk("reset_rd_data", rd_data_out, 32'd0);
    chk("reset_misalign", {31'd0, misalign_err_out}, 32'd0);
    mon_en = 1'b1;

    // ALU only
    step(1, 5'd5, 32'h1234_5678, 0, 0, 0, 0, 0);
    @(posedge clk_in); #1;
    chk("alu_data", rd_data_out, 32'h1234_5678);
    chk("alu_rd", {27'd0, rd_addr_out}, 32'd5);
    idle(1);

    // Load bypass formatting
    step(0, 0, 0, 1, 5'd1, 32'h80FF_7F01, 3'd0, 2'd2);
    @(posedge clk_in); #1; chk("lb_lo2", rd_data_out, 32'hFFFF_FFFF);
    step(0, 0, 0, 1, 5'd2, 32'h80FF_7F01, 3'd4, 2'd3);
    @(posedge clk_in); #1; chk("lbu_lo3", rd_data_out, 32'h0000_0080);
    step(0, 0, 0, 1, 5'd3, 32'h80FF_7F01, 3'd1, 2'd2);
    @(posedge clk_in); #1; chk("lh_lo2", rd_data_out, 32'hFFFF_80FF);
    step(0, 0, 0, 1, 5'd4, 32'h80FF_7F01, 3'd5, 2'd0);
    @(posedge clk_in); #1; chk("lhu_lo0", rd_data_out, 32'h0000_7F01);
    idle(1);

    // Contention: ALU every cycle, loads to rd 7, 8, then a third load
    step(1, 5'd20, 32'hA0, 1, 5'd7, 32'h77, 3'd2, 2'd0);
    step(1, 5'd21, 32'hA1, 1, 5'd8, 32'h88, 3'd2, 2'd0);
    step(1, 5'd22, 32'hA2, 1, 5'd10, 32'h10, 3'd2, 2'd0);
    chk("full_alu_ready", {31'd0, alu_ready_out}, 32'd0);
    @(posedge clk_in); #1;
    chk("drain_first_rd", {27'd0, rd_addr_out}, 32'd7);
    for (int i = 0; i < 4; i++) step(1, 5'(23 + i), 32'hB0 + i, 0, 0, 0, 0, 0);
    idle(4);

    // Misaligned lw
    step(0, 0, 0, 1, 5'd9, 32'hCAFE_F00D, 3'd2, 2'd1);
    @(posedge clk_in); #1;
    chk("mis_pulse", {31'd0, misalign_err_out}, 32'd1);
    chk("mis_no_write", {31'd0, wr_en_out}, 32'd0);
    chk("mis_no_pending", {31'd0, ld_pending_out}, 32'd0);
    idle(2);

    // rd = 0 from the ALU and from a queued load
    step(1, 5'd0, 32'h0000_DEAD, 0, 0, 0, 0, 0);
    @(posedge clk_in); #1; chk("alu_rd0_wr_en", {31'd0, wr_en_out}, 32'd0);
    step(1, 5'd6, 32'h66, 1, 5'd0, 32'h1, 3'd2, 2'd0);
    idle(3);

    // Reset while the FIFO is full
    step(1, 5'd13, 32'hD0, 1, 5'd11, 32'h11, 3'd2, 2'd0);
    step(1, 5'd14, 32'hD1, 1, 5'd12, 32'h12, 3'd2, 2'd0);
    do_reset();
    chk("rst_wr_en", {31'd0, wr_en_out}, 32'd0);
    chk("rst_pending", {31'd0, ld_pending_out}, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready_out}, 32'd1);
    chk("rst_ld_ready", {31'd0, ld_ready_out}, 32'd1);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
           f3s[$urandom_range(0, 7)], 2'($urandom_range(0, 3)));
      if (i == 200) do_reset();
    end
    idle(6);
    chk("scoreboard_empty", eq.size(), 32'd0);
    chk("misalign_queue_empty", mis_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback stage that produces the register-file write port (destination address, write data, write enable). It merges two result sources onto that single port:
- single-cycle ALU results;
- load results from the data-memory interface, which return with variable latency.
Load data is aligned and sign- or zero-extended here. Load results wait in a small FIFO while the ALU holds the port; the ALU stalls only when that FIFO is full.

Parameters:
DEPTH, 2, load-result FIFO entries; power of two, >= 2.

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_in  input  1  synchronous active-high reset
alu_valid_in  input  1  ALU result present
alu_ready_out  output  1  ALU result accepted this cycle when high with alu_valid_in
alu_rd_in  input  5  ALU destination register
alu_data_in  input  32  ALU result
ld_valid_in  input  1  load data present
ld_ready_out  output  1  load accepted this cycle when high with ld_valid_in
ld_rd_in  input  5  load destination register
ld_data_in  input  32  raw aligned memory word
ld_funct3_in  input  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
ld_addr_lo_in  input  2  byte address bits [1:0]
rd_addr_out  output  5  register-file write address
rd_data_out  output  32  register-file write data
wr_en_out  output  1  register-file write enable
misalign_err_out  output  1  one-cycle pulse: load discarded
ld_pending_out  output  1  FIFO non-empty

Behaviour:
- Reset (synchronous, rst_in high at an edge):
  - clears FIFO contents and count, read pointer and write pointer;
  - wr_en_out, rd_addr_out, rd_data_out and misalign_err_out go to 0;
  - outstanding entries are discarded, including when reset is asserted mid-drain.
- Handshakes:
  - alu_ready_out = ld_ready_out = (count < DEPTH), combinational from registered count only.
  - A transfer happens when valid and ready are both high at the edge.
- Load formatting, applied at acceptance, before the FIFO:
  - lb/lbu: byte ld_addr_lo_in*8 +: 8, sign-/zero-extended.
  - lh/lhu: halfword at ld_addr_lo_in[1]*16, sign-/zero-extended.
  - lw: word unchanged.
  - Undefined funct3 (011, 110, 111) is treated as lw.
- Misalignment:
  - Cases: lh/lhu with ld_addr_lo_in[0]=1; lw with ld_addr_lo_in != 0.
  - The load is accepted but not written.
  - misalign_err_out = 1 for exactly one cycle after acceptance; no FIFO push.
- Write-port selection each cycle, in priority order (one write per cycle):
  1. count == DEPTH: pop FIFO head to the port; ALU stalled.
  2. alu_valid_in && count < DEPTH: ALU result to the port; an accepted load is pushed.
  3. count > 0: pop FIFO head; an accepted load is pushed (push and pop in the same cycle leave count unchanged).
  4. count == 0 and an accepted, aligned load: bypass straight to the port; no push.
  5. Otherwise no write.
- Output timing:
  - Outputs are registered: latency is 1 cycle from acceptance (ALU or bypass) or from pop.
  - When nothing is selected, wr_en_out = 0 and rd_addr_out/rd_data_out hold their previous values.
- rd = 0 rule: a selected item with rd = 0 is consumed (popped/accepted) but drives wr_en_out = 0.
- FIFO ordering: load results are written in acceptance order.
  - Relative order of ALU and load writes to the same rd is the issuer's responsibility.
  - ld_pending_out lets the issuer detect this hazard.
- FIFO pointers: log2(DEPTH) bits, wrap modulo DEPTH. Count: log2(DEPTH)+1 bits, never exceeds DEPTH and never underflows.

Test Plan:
- Reset, then ALU only: alu_valid_in=1, rd=5, data=0x1234_5678 -> next cycle wr_en_out=1, rd_addr_out=5, rd_data_out=0x12345678; alu_ready_out stays 1.
- Load bypass formatting: ld_data_in=0x80FF_7F01 with idle ALU.
  - lb, addr_lo=2 -> rd_data_out=0xFFFFFFFF.
  - lbu, addr_lo=3 -> 0x00000080.
  - lh, addr_lo=2 -> 0xFFFF80FF.
  - lhu, addr_lo=0 -> 0x00007F01.
- Contention (DEPTH=2): ALU valid every cycle plus loads to rd 7 then 8.
  - Loads queue and ld_pending_out=1.
  - The third load sees ld_ready_out=0 with count=2; alu_ready_out=0 for that cycle.
  - FIFO drains rd 7 then rd 8 in order; then ALU resumes.
- Misaligned lw (addr_lo=1, rd=9) -> misalign_err_out high exactly one cycle, wr_en_out=0, count unchanged.
- rd=0: ALU rd=0 data=0xDEAD -> wr_en_out=0. Queued load with rd=0 is popped with no write and count decrements.
- Reset mid-drain: FIFO count=2, assert rst_in one cycle -> next cycle wr_en_out=0, ld_pending_out=0, both ready outputs=1, no stale writes afterwards.
